// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types, constants and exponent approximation for the softmax sequencer
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXP,
        ST_DIV,
        ST_OUT
    } state_e;

    localparam int TH_0 = -32;
    localparam int TH_1 = -16;
    localparam int TH_2 = 0;
    localparam int TH_3 = 16;
    localparam int TH_4 = 32;

    localparam logic [7:0] EXP_L0 = 8'd1;
    localparam logic [7:0] EXP_L1 = 8'd4;
    localparam logic [7:0] EXP_L2 = 8'd16;
    localparam logic [7:0] EXP_L3 = 8'd64;
    localparam logic [7:0] EXP_L4 = 8'd128;
    localparam logic [7:0] EXP_L5 = 8'd255;

    localparam int Q_SCALE = 256;
    localparam int Q_SHIFT = 8;

    // Piecewise staircase standing in for e^x; never returns zero so the sum is always non-zero.
    function automatic logic [7:0] approx_exp(input int x);
        logic [7:0] r;
        if (x <= TH_0)      r = EXP_L0;
        else if (x <= TH_1) r = EXP_L1;
        else if (x <= TH_2) r = EXP_L2;
        else if (x <= TH_3) r = EXP_L3;
        else if (x <= TH_4) r = EXP_L4;
        else                r = EXP_L5;
        return r;
    endfunction

endpackage

// File: rtl/softmax_seq_ctrl_seq_divider.sv
// rtl/softmax_seq_ctrl_seq_divider.sv - restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, rem_in, rem_d;
    logic [DIVIDEND_W-1:0] sr_q, sr_in, sr_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_in;
    logic [CNT_W-1:0]      cnt_q;
    logic                  active_q, done_q, zero_q;
    logic [DIVISOR_W:0]    trial;
    logic                  qbit;

    // The start cycle already performs the first iteration, so a divide spans DIVIDEND_W edges.
    always_comb begin
        rem_in = start_i ? '0 : rem_q;
        sr_in  = start_i ? dividend_i : sr_q;
        dvs_in = start_i ? divisor_i : dvs_q;
        trial  = {rem_in, sr_in[DIVIDEND_W-1]};
        qbit   = 1'b0;
        rem_d  = trial[DIVISOR_W-1:0];
        if (trial >= {1'b0, dvs_in}) begin
            qbit  = 1'b1;
            rem_d = DIVISOR_W'(trial - {1'b0, dvs_in});
        end
        sr_d = {sr_in[DIVIDEND_W-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            sr_q     <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q    <= rem_d;
                sr_q     <= sr_d;
                dvs_q    <= divisor_i;
                zero_q   <= (divisor_i == '0);
                cnt_q    <= CNT_W'(DIVIDEND_W - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= rem_d;
                sr_q  <= sr_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = zero_q ? '0 : sr_q;

endmodule

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - load, exponentiate, divide and emit one softmax vector at a time
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8,
    parameter int EXP_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int SUM_W     = EXP_W + $clog2(N_IN) + 1;
    localparam int DIV_ITERS = EXP_W + 8;
    localparam int IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);

    state_e                   state_q;
    logic signed [DATA_W-1:0] logit_q [N_IN];
    logic [EXP_W-1:0]         exp_q   [N_IN];
    logic [SUM_W-1:0]         sum_q;
    logic [IDX_W-1:0]         load_cnt_q, idx_q;
    logic                     in_ready_q, out_valid_q, out_last_q, busy_q, div_start_q;
    logic [DATA_W-1:0]        out_data_q;

    logic [EXP_W-1:0]         exp_val;
    logic [DIV_ITERS-1:0]     dividend, quotient;
    logic                     div_done;
    logic [DATA_W-1:0]        prob_sat;

    // idx_q walks the elements both during EXP and during DIV/OUT.
    assign exp_val  = EXP_W'(approx_exp(int'(logit_q[idx_q])));
    assign dividend = {exp_q[idx_q], {Q_SHIFT{1'b0}}};
    assign prob_sat = (|quotient[DIV_ITERS-1:DATA_W]) ? {DATA_W{1'b1}} : quotient[DATA_W-1:0];

    seq_divider #(
        .DIVIDEND_W(DIV_ITERS),
        .DIVISOR_W (SUM_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (div_start_q),
        .dividend_i(dividend),
        .divisor_i (sum_q),
        .done_o    (div_done),
        .quotient_o(quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            load_cnt_q  <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                logit_q[i] <= '0;
                exp_q[i]   <= '0;
            end
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        logit_q[load_cnt_q] <= in_data;
                        if (load_cnt_q == LAST) begin
                            load_cnt_q <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            sum_q      <= '0;
                            idx_q      <= '0;
                            state_q    <= ST_EXP;
                        end else begin
                            load_cnt_q <= load_cnt_q + IDX_W'(1);
                        end
                    end
                end
                ST_EXP: begin
                    exp_q[idx_q] <= exp_val;
                    sum_q        <= sum_q + SUM_W'(exp_val);
                    if (idx_q == LAST) begin
                        idx_q       <= '0;
                        div_start_q <= 1'b1;
                        state_q     <= ST_DIV;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= prob_sat;
                        out_last_q  <= (idx_q == LAST);
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (idx_q == LAST) begin
                            idx_q      <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            idx_q       <= idx_q + IDX_W'(1);
                            div_start_q <= 1'b1;
                            state_q     <= ST_DIV;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb/tb_softmax_seq_ctrl.sv - directed-vector bench for the softmax sequencer
module tb_softmax_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy;
    logic [7:0] in_data = 8'd0, out_data;
    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, out_last1, busy1;
    logic [7:0] in_data1 = 8'd0, out_data1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    softmax_seq_ctrl #(.N_IN(4), .DATA_W(8), .EXP_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    softmax_seq_ctrl #(.N_IN(1), .DATA_W(8), .EXP_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
    );

    task automatic send4(input int l0, input int l1, input int l2, input int l3);
        int v[4];
        int t;
        v = '{l0, l1, l2, l3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(v[i]);
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            n_vec++;
            if (!in_ready) begin
                n_err++;
                $display("FAIL send_timeout elem %0d: in_ready=%b required 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input string nm, input int e0, input int e1, input int e2, input int e3,
                        input int first, input int last, input bit chk_gap);
        int e[4];
        int t;
        e = '{e0, e1, e2, e3};
        for (int i = first; i <= last; i++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL %s_valid_timeout elem %0d: out_valid=%b required 1", nm, i, out_valid);
            end
            n_vec++;
            if (out_data !== 8'(e[i])) begin
                n_err++;
                $display("FAIL %s_data elem %0d: got %0d required %0d", nm, i, out_data, e[i]);
            end
            n_vec++;
            if (out_last !== (i == 3)) begin
                n_err++;
                $display("FAIL %s_last elem %0d: got %b required %b", nm, i, out_last, (i == 3));
            end
            if (chk_gap && i > first) begin
                n_vec++;
                if (t !== 25) begin
                    n_err++;
                    $display("FAIL %s_gap elem %0d: got %0d cycles required 25", nm, i, t);
                end
            end
            @(negedge clk);
        end
        if (last == 3) begin
            n_vec++;
            if (busy !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s_idle: busy=%b in_ready=%b required 0/1", nm, busy, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({in_ready, out_valid, out_data, out_last, busy} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%0d last=%b busy=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy, in_ready1, busy1} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b vld=%b busy=%b rdy1=%b busy1=%b required 1/0/0/1/0",
                     in_ready, out_valid, busy, in_ready1, busy1);
        end
    endtask

    task automatic test_basic();
        int t;
        send4(-40, -20, 0, 40);
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: busy=%b in_ready=%b required 1/0", busy, in_ready);
        end
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t !== 29) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles required 29", t);
        end
        recv("basic", 0, 3, 14, 236, 0, 3, 1'b1);
    endtask

    task automatic test_uniform();
        send4(0, 0, 0, 0);
        recv("zeros", 64, 64, 64, 64, 0, 3, 1'b0);
        send4(100, 100, 100, 100);
        recv("hundreds", 64, 64, 64, 64, 0, 3, 1'b0);
    endtask

    task automatic test_thresholds();
        int lg[10];
        int ex[10];
        int s, p0, p1;
        lg = '{-128, -32, -31, -16, -15, 16, 17, 32, 33, 127};
        ex = '{1, 1, 4, 4, 16, 64, 128, 128, 255, 255};
        for (int i = 0; i < 10; i++) begin
            s  = ex[i] + 3;
            p0 = (ex[i] * 256) / s;
            if (p0 > 255) p0 = 255;
            p1 = 256 / s;
            send4(lg[i], -128, -128, -128);
            recv($sformatf("thr%0d", lg[i]), p0, p1, p1, p1, 0, 3, 1'b0);
        end
    endtask

    task automatic test_n1();
        int t;
        in_valid1 = 1'b1;
        in_data1  = 8'd127;
        t = 0;
        while (!in_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        t = 0;
        while (!out_valid1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t !== 26) begin
            n_err++;
            $display("FAIL n1_latency: got %0d cycles required 26", t);
        end
        n_vec++;
        if (out_data1 !== 8'd255) begin
            n_err++;
            $display("FAIL n1_data: got %0d required 255", out_data1);
        end
        n_vec++;
        if (out_last1 !== 1'b1) begin
            n_err++;
            $display("FAIL n1_last: got %b required 1", out_last1);
        end
        @(negedge clk);
        n_vec++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL n1_idle: busy=%b out_valid=%b required 0/0", busy1, out_valid1);
        end
    endtask

    task automatic test_stall();
        int t;
        send4(-40, -20, 0, 40);
        recv("stall", 0, 3, 14, 236, 0, 0, 1'b0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'd3 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cyc %0d: vld=%b data=%0d last=%b rdy=%b required 1/3/0/0",
                         c, out_valid, out_data, out_last, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        recv("stall", 0, 3, 14, 236, 2, 3, 1'b0);
    endtask

    task automatic test_reset_mid_div();
        send4(40, 0, -20, -40);
        recv("abort", 236, 14, 3, 0, 0, 0, 1'b0);
        repeat (8) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd236) begin
            n_err++;
            $display("FAIL abort_pre: busy=%b vld=%b data=%0d required 1/0/236", busy, out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_data, out_last, busy} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_async: rdy=%b vld=%b data=%0d last=%b busy=%b required 1/0/0/0/0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send4(-40, -20, 0, 40);
        recv("after_abort", 0, 3, 14, 236, 0, 3, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_uniform();
        test_thresholds();
        test_n1();
        test_stall();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
